// File: rtl/ysyx_wbu_if.sv
// Execute-stage handshake plus register-file GPR/CSR ports of the write-back unit.
// The slave modport is the write-back unit; the master modport is the surrounding core.
interface ysyx_wbu_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [31:0] in_rd_data;
  logic [1:0]  in_csr_op;
  logic [11:0] in_csr_addr;
  logic [31:0] in_csr_src;
  logic        in_is_ecall;
  logic        in_is_mret;
  logic [31:0] in_a7;
  logic        rf_wr_en;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wr_en;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [63:0] instret;

  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_we, in_rd_data, in_csr_op, in_csr_addr,
           in_csr_src, in_is_ecall, in_is_mret, in_a7, csr_rdata,
    output in_ready, rf_wr_en, rf_waddr, rf_wdata, csr_raddr, csr_wr_en, csr_waddr,
           csr_wdata, redirect_valid, redirect_pc, commit_valid, commit_pc, instret
  );

  modport master (
    output in_valid, in_pc, in_rd, in_rd_we, in_rd_data, in_csr_op, in_csr_addr,
           in_csr_src, in_is_ecall, in_is_mret, in_a7, csr_rdata,
    input  in_ready, rf_wr_en, rf_waddr, rf_wdata, csr_raddr, csr_wr_en, csr_waddr,
           csr_wdata, redirect_valid, redirect_pc, commit_valid, commit_pc, instret
  );
endinterface

// File: rtl/ysyx_wbu.sv
// Write-back unit: sequences GPR write, CSR read-modify-write, ecall trap entry and mret.
// Define YSYX_WBU_INSTRET_EN to build the 64-bit retired-instruction counter.
module ysyx_wbu (
  input  logic        clk,
  input  logic        rst_n,
  ysyx_wbu_if.slave   bus
);
  localparam logic [11:0] MEPC   = 12'h341;
  localparam logic [11:0] MCAUSE = 12'h342;
  localparam logic [11:0] MTVEC  = 12'h305;

  typedef enum logic [2:0] {IDLE, WB, CSR_RD, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET} state_t;
  state_t state, state_nxt;

  logic [31:0] pc_q, rd_data_q, csr_src_q, a7_q, old_q, csr_new;
  logic [4:0]  rd_q;
  logic        rd_we_q;
  logic [1:0]  csr_op_q;
  logic [11:0] csr_addr_q;
  logic        accept;

  logic        in_ready, rf_wr_en, csr_wr_en, redirect_valid, commit;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_wdata, redirect_pc, commit_pc;
  logic [11:0] csr_raddr, csr_waddr;

  assign accept = (state == IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Inputs are captured only in the accept cycle; later changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      rd_data_q  <= '0;
      csr_op_q   <= '0;
      csr_addr_q <= '0;
      csr_src_q  <= '0;
      a7_q       <= '0;
      old_q      <= '0;
    end else begin
      if (accept) begin
        pc_q       <= bus.in_pc;
        rd_q       <= bus.in_rd;
        rd_we_q    <= bus.in_rd_we;
        rd_data_q  <= bus.in_rd_data;
        csr_op_q   <= bus.in_csr_op;
        csr_addr_q <= bus.in_csr_addr;
        csr_src_q  <= bus.in_csr_src;
        a7_q       <= bus.in_a7;
      end
      if (state == CSR_RD) old_q <= bus.csr_rdata;
    end
  end

  always_comb begin
    case (csr_op_q)
      2'b10:   csr_new = old_q | csr_src_q;
      2'b11:   csr_new = old_q & ~csr_src_q;
      default: csr_new = csr_src_q;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    rf_wr_en       = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    csr_raddr      = '0;
    csr_wr_en      = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    commit         = 1'b0;
    commit_pc      = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (bus.in_is_ecall)            state_nxt = TRAP_EPC;
          else if (bus.in_is_mret)        state_nxt = MRET;
          else if (bus.in_csr_op != 2'b00) state_nxt = CSR_RD;
          else                            state_nxt = WB;
        end
      end
      WB: begin
        if (rd_we_q && rd_q != 5'd0) begin
          rf_wr_en = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = rd_data_q;
        end
        commit    = 1'b1;
        commit_pc = pc_q;
        state_nxt = IDLE;
      end
      CSR_RD: begin
        csr_raddr = csr_addr_q;
        state_nxt = CSR_WR;
      end
      CSR_WR: begin
        csr_wr_en = 1'b1;
        csr_waddr = csr_addr_q;
        csr_wdata = csr_new;
        // The old value goes to rd regardless of in_rd_we.
        if (rd_q != 5'd0) begin
          rf_wr_en = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = old_q;
        end
        commit    = 1'b1;
        commit_pc = pc_q;
        state_nxt = IDLE;
      end
      TRAP_EPC: begin
        csr_wr_en = 1'b1;
        csr_waddr = MEPC;
        csr_wdata = pc_q;
        state_nxt = TRAP_CAUSE;
      end
      TRAP_CAUSE: begin
        csr_wr_en = 1'b1;
        csr_waddr = MCAUSE;
        csr_wdata = a7_q;
        state_nxt = TRAP_VEC;
      end
      TRAP_VEC: begin
        csr_raddr      = MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = bus.csr_rdata;
        commit         = 1'b1;
        commit_pc      = pc_q;
        state_nxt      = IDLE;
      end
      MRET: begin
        csr_raddr      = MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = bus.csr_rdata;
        commit         = 1'b1;
        commit_pc      = pc_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready       = in_ready;
  assign bus.rf_wr_en       = rf_wr_en;
  assign bus.rf_waddr       = rf_waddr;
  assign bus.rf_wdata       = rf_wdata;
  assign bus.csr_raddr      = csr_raddr;
  assign bus.csr_wr_en      = csr_wr_en;
  assign bus.csr_waddr      = csr_waddr;
  assign bus.csr_wdata      = csr_wdata;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.commit_valid   = commit;
  assign bus.commit_pc      = commit_pc;

`ifdef YSYX_WBU_INSTRET_EN
  logic [63:0] instret_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (commit) instret_q <= instret_q + 64'd1;
  end
  assign bus.instret = instret_q;
`else
  assign bus.instret = '0;
`endif
endmodule

// File: tb/tb_ysyx_wbu.sv
// Bench for ysyx_wbu: transaction-level model expands each accepted instruction into
// its expected per-cycle outputs; one compare step checks every cycle, plus directed literals.
module tb_ysyx_wbu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_wbu_if bus();
  ysyx_wbu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // CSR file seen by the DUT (environment) and the model's own copy.
  bit [31:0] csr_mem [4096];
  bit [31:0] mcsr [4096];
  assign bus.csr_rdata = csr_mem[bus.csr_raddr];
  always @(posedge clk) if (bus.csr_wr_en) csr_mem[bus.csr_waddr] <= bus.csr_wdata;

  typedef struct packed {
    logic        ecall, mret;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src, pc, data, a7;
    logic [4:0]  rd;
    logic        we;
  } ins_t;

  typedef struct packed {
    logic        in_ready, rf_wr_en;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [11:0] csr_raddr;
    logic        csr_wr_en;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        commit_valid;
    logic [31:0] commit_pc;
  } obs_t;

  obs_t        expq[$];
  obs_t        last;
  bit          cur_idle;
  logic [63:0] n_commit = '0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                              input logic [31:0] data, input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] src, input logic ec, input logic mr, input logic [31:0] a7);
    ins_t i;
    i.pc = pc; i.rd = rd; i.we = we; i.data = data; i.op = op; i.addr = addr;
    i.src = src; i.ecall = ec; i.mret = mr; i.a7 = a7;
    return i;
  endfunction

  // Expand one accepted instruction into the cycles it must produce, starting at accept+1.
  function automatic void accept_model(input ins_t i);
    obs_t c;
    logic [31:0] old, nv;
    if (i.ecall) begin
      c = '0; c.csr_wr_en = 1'b1; c.csr_waddr = 12'h341; c.csr_wdata = i.pc; expq.push_back(c);
      mcsr[12'h341] = i.pc;
      c = '0; c.csr_wr_en = 1'b1; c.csr_waddr = 12'h342; c.csr_wdata = i.a7; expq.push_back(c);
      mcsr[12'h342] = i.a7;
      c = '0; c.csr_raddr = 12'h305; c.redirect_valid = 1'b1; c.redirect_pc = mcsr[12'h305];
      c.commit_valid = 1'b1; c.commit_pc = i.pc; expq.push_back(c);
    end else if (i.mret) begin
      c = '0; c.csr_raddr = 12'h341; c.redirect_valid = 1'b1; c.redirect_pc = mcsr[12'h341];
      c.commit_valid = 1'b1; c.commit_pc = i.pc; expq.push_back(c);
    end else if (i.op != 2'b00) begin
      old = mcsr[i.addr];
      nv  = (i.op == 2'b01) ? i.src : (i.op == 2'b10) ? (old | i.src) : (old & ~i.src);
      c = '0; c.csr_raddr = i.addr; expq.push_back(c);
      c = '0; c.csr_wr_en = 1'b1; c.csr_waddr = i.addr; c.csr_wdata = nv;
      if (i.rd != 5'd0) begin c.rf_wr_en = 1'b1; c.rf_waddr = i.rd; c.rf_wdata = old; end
      c.commit_valid = 1'b1; c.commit_pc = i.pc; expq.push_back(c);
      mcsr[i.addr] = nv;
    end else begin
      c = '0;
      if (i.we && i.rd != 5'd0) begin c.rf_wr_en = 1'b1; c.rf_waddr = i.rd; c.rf_wdata = i.data; end
      c.commit_valid = 1'b1; c.commit_pc = i.pc; expq.push_back(c);
    end
  endfunction

  task automatic compare();
    obs_t o, e;
    logic [63:0] ei;
    o.in_ready = bus.in_ready;             o.rf_wr_en = bus.rf_wr_en;
    o.rf_waddr = bus.rf_waddr;             o.rf_wdata = bus.rf_wdata;
    o.csr_raddr = bus.csr_raddr;           o.csr_wr_en = bus.csr_wr_en;
    o.csr_waddr = bus.csr_waddr;           o.csr_wdata = bus.csr_wdata;
    o.redirect_valid = bus.redirect_valid; o.redirect_pc = bus.redirect_pc;
    o.commit_valid = bus.commit_valid;     o.commit_pc = bus.commit_pc;
    cur_idle = (expq.size() == 0);
    if (cur_idle) begin e = '0; e.in_ready = 1'b1; end
    else e = expq.pop_front();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL cycle_outputs t=%0t act=%h exp=%h", $time, o, e);
    end
`ifdef YSYX_WBU_INSTRET_EN
    ei = n_commit;
`else
    ei = 64'd0;
`endif
    chk("instret", bus.instret, ei);
    if (e.commit_valid) n_commit++;
    last = o;
  endtask

  task automatic drive(input ins_t i, input logic v);
    bus.in_valid    = v;
    bus.in_pc       = i.pc;
    bus.in_rd       = i.rd;
    bus.in_rd_we    = i.we;
    bus.in_rd_data  = i.data;
    bus.in_csr_op   = i.op;
    bus.in_csr_addr = i.addr;
    bus.in_csr_src  = i.src;
    bus.in_is_ecall = i.ecall;
    bus.in_is_mret  = i.mret;
    bus.in_a7       = i.a7;
  endtask

  task automatic tick(input ins_t i, input logic v);
    @(negedge clk);
    compare();
    drive(i, v);
    if (cur_idle && v) accept_model(i);
  endtask

  function automatic ins_t rnd_ins();
    ins_t i;
    int k;
    i.pc = $urandom; i.data = $urandom; i.a7 = $urandom;
    i.src = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    i.rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    i.we = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0: i.addr = 12'h300;
      1: i.addr = 12'h305;
      2: i.addr = 12'h341;
      3: i.addr = 12'h342;
      default: i.addr = 12'($urandom);
    endcase
    k = $urandom_range(0, 9);
    i.ecall = (k == 0);
    i.mret  = (k == 1) || (k == 2 && $urandom_range(0, 1) == 1);
    i.op    = (k < 6) ? 2'($urandom) : 2'b00;
    return i;
  endfunction

  initial begin
    ins_t z, a, e;
    logic [31:0] old342;
    z = '0;
    drive(z, 1'b0);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_commit", bus.commit_valid, 0);
    chk("rst_instret", bus.instret, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Plain write, then rd=0 still commits without a GPR write.
    tick(mk(32'h80000000, 5'd5, 1'b1, 32'hDEADBEEF, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0), 1'b1);
    tick(z, 1'b0);
    chk("plain_we", last.rf_wr_en, 1);
    chk("plain_waddr", last.rf_waddr, 5);
    chk("plain_wdata", last.rf_wdata, 32'hDEADBEEF);
    chk("plain_cpc", last.commit_pc, 32'h80000000);
    tick(mk(32'h80000004, 5'd0, 1'b1, 32'h12345678, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0), 1'b1);
    tick(z, 1'b0);
    chk("rd0_we", last.rf_wr_en, 0);
    chk("rd0_commit", last.commit_valid, 1);

    // mstatus=0x1800, then CSRRS src=8 into x10.
    tick(mk(32'h80000008, 5'd0, 1'b0, 32'h0, 2'b01, 12'h300, 32'h00001800, 1'b0, 1'b0, 32'h0), 1'b1);
    repeat (2) tick(z, 1'b0);
    tick(mk(32'h8000000C, 5'd10, 1'b0, 32'h0, 2'b10, 12'h300, 32'h8, 1'b0, 1'b0, 32'h0), 1'b1);
    tick(z, 1'b0);
    chk("rs_raddr", last.csr_raddr, 12'h300);
    tick(z, 1'b0);
    chk("rs_wdata", last.csr_wdata, 32'h00001808);
    chk("rs_waddr", last.csr_waddr, 12'h300);
    chk("rs_rf_waddr", last.rf_waddr, 10);
    chk("rs_rf_wdata", last.rf_wdata, 32'h00001800);
    tick(mk(32'h80000010, 5'd0, 1'b0, 32'h0, 2'b01, 12'h300, 32'h00001800, 1'b0, 1'b0, 32'h0), 1'b1);
    repeat (2) tick(z, 1'b0);
    tick(mk(32'h80000014, 5'd0, 1'b0, 32'h0, 2'b11, 12'h300, 32'h800, 1'b0, 1'b0, 32'h0), 1'b1);
    repeat (2) tick(z, 1'b0);
    chk("rc_wdata", last.csr_wdata, 32'h00001000);

    // mtvec and mepc setup, then mret.
    tick(mk(32'h80000018, 5'd0, 1'b0, 32'h0, 2'b01, 12'h305, 32'h80000400, 1'b0, 1'b0, 32'h0), 1'b1);
    repeat (2) tick(z, 1'b0);
    tick(mk(32'h8000001C, 5'd0, 1'b0, 32'h0, 2'b01, 12'h341, 32'h80000104, 1'b0, 1'b0, 32'h0), 1'b1);
    repeat (2) tick(z, 1'b0);
    tick(mk(32'h80000020, 5'd3, 1'b1, 32'h0, 2'b00, 12'h0, 32'h0, 1'b0, 1'b1, 32'h0), 1'b1);
    tick(z, 1'b0);
    chk("mret_redir", last.redirect_valid, 1);
    chk("mret_pc", last.redirect_pc, 32'h80000104);

    // Ecall: mepc, mcause, then redirect to mtvec; no GPR write.
    tick(mk(32'h80000100, 5'd7, 1'b1, 32'hFFFF, 2'b00, 12'h0, 32'h0, 1'b1, 1'b0, 32'd11), 1'b1);
    tick(z, 1'b0);
    chk("ec_epc_addr", last.csr_waddr, 12'h341);
    chk("ec_epc_data", last.csr_wdata, 32'h80000100);
    tick(z, 1'b0);
    chk("ec_cause_addr", last.csr_waddr, 12'h342);
    chk("ec_cause_data", last.csr_wdata, 32'd11);
    tick(z, 1'b0);
    chk("ec_redir_pc", last.redirect_pc, 32'h80000400);
    chk("ec_no_gpr", last.rf_wr_en, 0);

    // Reset asserted during TRAP_CAUSE: mcause write must not land, no redirect follows.
    old342 = mcsr[12'h342];
    tick(mk(32'h80000200, 5'd1, 1'b1, 32'h0, 2'b00, 12'h0, 32'h0, 1'b1, 1'b0, 32'h55), 1'b1);
    tick(z, 1'b0);
    tick(z, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_csr_we", bus.csr_wr_en, 0);
    chk("arst_csr_wdata", bus.csr_wdata, 0);
    chk("arst_instret", bus.instret, 0);
    expq.delete();
    mcsr[12'h342] = old342;
    n_commit = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      tick(z, 1'b0);
      chk("arst_no_redir", last.redirect_valid, 0);
    end
    chk("arst_mcause", csr_mem[12'h342], 32'd11);

    // ecall+CSRRS held valid: trap wins, in_ready low three cycles; then three plain commits.
    e = mk(32'h80000300, 5'd9, 1'b1, 32'h0, 2'b10, 12'h300, 32'hF, 1'b1, 1'b0, 32'd8);
    tick(e, 1'b1);
    repeat (3) begin
      tick(e, 1'b1);
      chk("prio_ready_low", last.in_ready, 0);
    end
    chk("prio_redir_pc", last.redirect_pc, 32'h80000400);
    a = mk(32'h80000304, 5'd4, 1'b1, 32'h44, 2'b00, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      tick(a, 1'b1);
      tick(z, 1'b0);
    end
    tick(z, 1'b0);
`ifdef YSYX_WBU_INSTRET_EN
    chk("instret_four", bus.instret, 64'd4);
`else
    chk("instret_four", bus.instret, 64'd0);
`endif

    // Randomized traffic; fields change freely while busy and must be ignored.
    repeat (3000) tick(rnd_ins(), ($urandom_range(0, 3) != 0));
    repeat (6) tick(z, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
